// File: rtl/sisc_ctrl_p.sv
// Multi-cycle control FSM for the SISC core: fetch/decode/execute/mem/writeback sequencing.
// Define SISC_CTRL_SWP_EN to enable the two-cycle register swap (SWP) instruction.
module sisc_ctrl_p #(
   parameter int unsigned OP_W   = 4,
   parameter int unsigned STAT_W = 4,
   parameter int unsigned TMO_W  = 4
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic [OP_W-1:0]   opcode,
   input  logic [STAT_W-1:0] mm,
   input  logic [STAT_W-1:0] stat,
   input  logic              mem_ready,
   output logic              ir_load,
   output logic              pc_write,
   output logic              pc_sel,
   output logic              br_sel,
   output logic [1:0]        alu_op,
   output logic              rf_we,
   output logic              wb_sel,
   output logic              rd_sel,
   output logic              mem_req,
   output logic              mem_we,
   output logic              halted,
   output logic              err,
   output logic [3:0]        state
);

   typedef enum logic [3:0] {
      S_START1  = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_EXECUTE = 4'd3,
      S_MEM     = 4'd4,
      S_WB      = 4'd5,
      S_WB2     = 4'd6,
      S_HALT    = 4'd7,
      S_ERR     = 4'd8
   } state_t;

   localparam logic [OP_W-1:0] OP_NOOP = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LOD  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_STR  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SWP  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BRA  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BRR  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BNR  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_ALU  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_HLT  = OP_W'(15);

   localparam logic [STAT_W-1:0] MM_IMM = STAT_W'(8);
   // Last count before the limit: a MEM cycle without ready at this count times out.
   localparam logic [TMO_W-1:0]  TMO_PRE = ~TMO_W'(1);

   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             flag_hit;

   assign flag_hit = |(mm & stat);

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= S_START1;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmo_d    = '0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      alu_op   = 2'b00;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      rd_sel   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;

      case (state_q)
         S_START1: state_d = S_FETCH;

         S_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
         end

         S_DECODE: begin
            case (opcode)
               OP_HLT:  state_d = S_HALT;
               OP_NOOP: state_d = S_FETCH;
               OP_ALU, OP_LOD, OP_STR: state_d = S_EXECUTE;
`ifdef SISC_CTRL_SWP_EN
               OP_SWP:  state_d = S_EXECUTE;
`else
               OP_SWP:  state_d = S_ERR;
`endif
               OP_BRA, OP_BRR: begin
                  pc_write = flag_hit;
                  pc_sel   = flag_hit;
                  br_sel   = flag_hit && (opcode == OP_BRR);
                  state_d  = S_FETCH;
               end
               OP_BNE, OP_BNR: begin
                  pc_write = !flag_hit;
                  pc_sel   = !flag_hit;
                  br_sel   = !flag_hit && (opcode == OP_BNR);
                  state_d  = S_FETCH;
               end
               default: state_d = S_ERR;
            endcase
         end

         S_EXECUTE: begin
            if (opcode == OP_LOD || opcode == OP_STR) begin
               alu_op  = 2'b10;
               state_d = S_MEM;
            end else begin
               alu_op  = (opcode == OP_ALU && mm == MM_IMM) ? 2'b01 : 2'b00;
               state_d = S_WB;
            end
         end

         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (opcode == OP_STR);
            if (mem_ready) begin
               state_d = (opcode == OP_STR) ? S_FETCH : S_WB;
            end else if (tmo_q == TMO_PRE) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         S_WB: begin
            rf_we  = 1'b1;
            wb_sel = (opcode == OP_LOD);
`ifdef SISC_CTRL_SWP_EN
            state_d = (opcode == OP_SWP) ? S_WB2 : S_FETCH;
`else
            state_d = S_FETCH;
`endif
         end

         S_WB2: begin
            rf_we   = 1'b1;
            rd_sel  = 1'b1;
            state_d = S_FETCH;
         end

         S_HALT: halted = 1'b1;

         S_ERR: err = 1'b1;

         default: state_d = S_ERR;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_sisc_ctrl_p.sv
// Directed self-checking bench for sisc_ctrl_p (TMO_W=2 instance, so the timeout limit is 3 MEM cycles).
module tb_sisc_ctrl_p;

   localparam logic [3:0] ST_START1  = 4'd0;
   localparam logic [3:0] ST_FETCH   = 4'd1;
   localparam logic [3:0] ST_DECODE  = 4'd2;
   localparam logic [3:0] ST_EXECUTE = 4'd3;
   localparam logic [3:0] ST_MEM     = 4'd4;
   localparam logic [3:0] ST_WB      = 4'd5;
   localparam logic [3:0] ST_WB2     = 4'd6;
   localparam logic [3:0] ST_HALT    = 4'd7;
   localparam logic [3:0] ST_ERR     = 4'd8;

   logic       clk = 1'b0;
   logic       rst_f;
   logic [3:0] opcode, mm, stat;
   logic       mem_ready;
   logic       ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, rd_sel;
   logic       mem_req, mem_we, halted, err;
   logic [1:0] alu_op;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sisc_ctrl_p #(.OP_W(4), .STAT_W(4), .TMO_W(2)) dut (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
      .mem_ready(mem_ready), .ir_load(ir_load), .pc_write(pc_write),
      .pc_sel(pc_sel), .br_sel(br_sel), .alu_op(alu_op), .rf_we(rf_we),
      .wb_sel(wb_sel), .rd_sel(rd_sel), .mem_req(mem_req), .mem_we(mem_we),
      .halted(halted), .err(err), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset away from the edge, checks the reset state, releases, and steps into FETCH.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_f = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk({tag, "_rst_state"}, 32'(state), 32'(ST_START1));
      chk({tag, "_rst_outs"}, 32'({ir_load, pc_write, pc_sel, br_sel, alu_op, rf_we,
                                   wb_sel, rd_sel, mem_req, mem_we, halted, err}), 32'd0);
      @(negedge clk);
      rst_f = 1'b1;
      tick();
      chk({tag, "_first_fetch"}, 32'(state), 32'(ST_FETCH));
   endtask

   initial begin
      rst_f = 1'b0; opcode = 4'd8; mm = 4'd8; stat = 4'd0; mem_ready = 1'b0;
      #12;
      chk("reset_state", 32'(state), 32'(ST_START1));
      chk("reset_outs", 32'({ir_load, pc_write, pc_sel, br_sel, alu_op, rf_we,
                             wb_sel, rd_sel, mem_req, mem_we, halted, err}), 32'd0);
      @(negedge clk);
      rst_f = 1'b1;

      // ALU immediate: FETCH, DECODE, EXECUTE, WB, FETCH
      tick();
      chk("alu_fetch_state", 32'(state), 32'(ST_FETCH));
      chk("alu_fetch_ctl", 32'({ir_load, pc_write, pc_sel}), 32'b110);
      tick();
      chk("alu_decode", 32'(state), 32'(ST_DECODE));
      chk("alu_decode_pcw", 32'(pc_write), 32'd0);
      tick();
      chk("alu_exec", 32'(state), 32'(ST_EXECUTE));
      chk("alu_imm_op", 32'(alu_op), 32'b01);
      tick();
      chk("alu_wb", 32'(state), 32'(ST_WB));
      chk("alu_wb_ctl", 32'({rf_we, wb_sel, rd_sel}), 32'b100);
      tick();
      chk("alu_back_fetch", 32'(state), 32'(ST_FETCH));
      chk("alu_fetch_rfwe", 32'(rf_we), 32'd0);

      // ALU reg-reg, plus mem_ready held high outside MEM must be ignored
      mm = 4'd3; mem_ready = 1'b1;
      tick(); tick();
      chk("alu_rr_op", 32'(alu_op), 32'b00);
      chk("alu_rr_nomem", 32'(mem_req), 32'd0);
      tick(); tick();
      chk("alu_rr_fetch", 32'(state), 32'(ST_FETCH));
      mem_ready = 1'b0;

      // BRR taken then not taken, BNE taken (absolute)
      opcode = 4'd5; mm = 4'b0010; stat = 4'b0010;
      tick();
      chk("brr_taken", 32'({pc_write, pc_sel, br_sel}), 32'b111);
      tick();
      chk("brr_to_fetch", 32'(state), 32'(ST_FETCH));
      stat = 4'b0000;
      tick();
      chk("brr_not_taken", 32'({pc_write, pc_sel, br_sel}), 32'b000);
      tick();
      opcode = 4'd6; mm = 4'b0010; stat = 4'b0100;
      tick();
      chk("bne_taken", 32'({pc_write, pc_sel, br_sel}), 32'b110);
      stat = 4'b0110;
      #1;
      chk("bne_not_taken", 32'({pc_write, pc_sel, br_sel}), 32'b000);
      tick();
      chk("bne_to_fetch", 32'(state), 32'(ST_FETCH));

      // LOD with mem_ready on the 3rd MEM cycle, which is also the timeout-limit cycle
      opcode = 4'd1;
      tick(); tick();
      chk("lod_exec_op", 32'(alu_op), 32'b10);
      tick();
      chk("lod_mem1", 32'({mem_req, mem_we}), 32'b10);
      tick();
      chk("lod_mem2", 32'(state), 32'(ST_MEM));
      tick();
      chk("lod_mem3", 32'({mem_req, mem_we}), 32'b10);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("lod_wb_state", 32'(state), 32'(ST_WB));
      chk("lod_wb_ctl", 32'({rf_we, wb_sel, rd_sel, err}), 32'b1100);
      tick();
      chk("lod_wb_once", 32'({state, rf_we}), 32'({ST_FETCH, 1'b0}));

      // STR completing on MEM cycle 2
      opcode = 4'd2;
      tick(); tick(); tick();
      chk("str_mem_we", 32'({mem_req, mem_we}), 32'b11);
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("str_to_fetch", 32'(state), 32'(ST_FETCH));
      chk("str_no_wb", 32'({rf_we, mem_req}), 32'd0);

      // STR again, reset pulsed mid-MEM: outputs drop before the next edge
      tick(); tick(); tick();
      chk("str2_mem", 32'({state, mem_req, mem_we}), 32'({ST_MEM, 2'b11}));
      #2;
      rst_f = 1'b0;
      #1;
      chk("midmem_rst_state", 32'(state), 32'(ST_START1));
      chk("midmem_rst_mem", 32'({mem_req, mem_we}), 32'b00);
      #3;
      rst_f = 1'b1;
      tick();
      chk("midmem_rst_fetch", 32'(state), 32'(ST_FETCH));

      // SWP depends on build configuration
      opcode = 4'd3;
      tick();
      tick();
`ifdef SISC_CTRL_SWP_EN
      chk("swp_exec", 32'({state, alu_op}), 32'({ST_EXECUTE, 2'b00}));
      tick();
      chk("swp_wb", 32'({state, rf_we, rd_sel, wb_sel}), 32'({ST_WB, 3'b100}));
      tick();
      chk("swp_wb2", 32'({state, rf_we, rd_sel}), 32'({ST_WB2, 2'b11}));
      tick();
      chk("swp_done", 32'({state, rf_we}), 32'({ST_FETCH, 1'b0}));
`else
      chk("swp_undef_err", 32'({state, err}), 32'({ST_ERR, 1'b1}));
`endif
      do_reset("swp");

      // LOD timeout: no mem_ready, ERR after 3 MEM cycles (counter cleared on this entry)
      opcode = 4'd1;
      tick(); tick(); tick(); tick();
      tick();
      chk("tmo_mem3", 32'({state, err}), 32'({ST_MEM, 1'b0}));
      tick();
      chk("tmo_err", 32'({state, err, mem_req}), 32'({ST_ERR, 2'b10}));
      mem_ready = 1'b1;
      tick(); tick(); tick();
      chk("tmo_err_sticky", 32'({state, err}), 32'({ST_ERR, 1'b1}));
      do_reset("tmo");

      // Undefined opcode
      opcode = 4'd9;
      tick(); tick();
      chk("undef_err", 32'({state, err}), 32'({ST_ERR, 1'b1}));
      do_reset("undef");

      // NOOP returns to FETCH
      opcode = 4'd0;
      tick(); tick();
      chk("noop_fetch", 32'({state, ir_load}), 32'({ST_FETCH, 1'b1}));

      // HLT: halted held until reset
      opcode = 4'd15;
      tick(); tick();
      chk("hlt_state", 32'({state, halted}), 32'({ST_HALT, 1'b1}));
      for (int i = 0; i < 22; i++) begin
         opcode = 4'(i);
         mem_ready = i[0];
         tick();
         chk("hlt_hold", 32'({state, halted, pc_write, rf_we}), 32'({ST_HALT, 3'b100}));
      end
      do_reset("hlt");
      chk("hlt_cleared", 32'(halted), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
